// File: rtl/fifo_sync_param_if.sv
// Producer/consumer bus of fifo_sync_param: write side, read side and status flags.
// The master modport belongs to the user of the FIFO; the slave modport belongs to the FIFO.
interface fifo_sync_param_if #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] Din;
  logic                  WR_EN;
  logic                  RD_EN;
  logic [DATA_WIDTH-1:0] Dout;
  logic                  Dout_valid;
  logic                  full;
  logic                  Empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output Din, WR_EN, RD_EN,
    input  Dout, Dout_valid, full, Empty, almost_full, almost_empty, count, overflow, underflow
  );

  modport slave (
    input  Din, WR_EN, RD_EN,
    output Dout, Dout_valid, full, Empty, almost_full, almost_empty, count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised synchronous FIFO with register storage, occupancy count, almost flags,
// sticky overflow/underflow and a selectable standard or first-word-fall-through read port.
module fifo_sync_param #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned DEPTH      = 256,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned AF_LEVEL   = 240,
  parameter int unsigned AE_LEVEL   = 16,
  parameter int unsigned FWFT       = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             CLR,
  fifo_sync_param_if.slave bus
);

  localparam logic [ADDR_WIDTH:0]   DepthC  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0]   AfC     = (ADDR_WIDTH + 1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0]   AeC     = (ADDR_WIDTH + 1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  af_q, af_d;
  logic                  ae_q, ae_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;
  logic                  wr_acc, rd_acc;

  always_comb begin
    // A read frees a slot in the same cycle, so a full FIFO still takes a write alongside it.
    rd_acc   = bus.RD_EN && !empty_q && !CLR;
    wr_acc   = bus.WR_EN && (!full_q || rd_acc) && !CLR;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    unf_d    = unf_q;
    if (CLR) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end else begin
      if (wr_acc) wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
      if (rd_acc) rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
      if (wr_acc && !rd_acc) begin
        count_d = count_q + (ADDR_WIDTH + 1)'(1);
      end else if (rd_acc && !wr_acc) begin
        count_d = count_q - (ADDR_WIDTH + 1)'(1);
      end
      if (bus.WR_EN && !wr_acc) ovf_d = 1'b1;
      if (bus.RD_EN && !rd_acc) unf_d = 1'b1;
    end
    full_d  = (count_d == DepthC);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AfC);
    ae_d    = (count_d <= AeC);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  // Storage has no reset; contents are meaningless until written.
  always_ff @(posedge CLK) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.Din;
  end

  if (FWFT != 0) begin : g_fwft
    assign bus.Dout       = empty_q ? '0 : mem[rd_ptr_q];
    assign bus.Dout_valid = !empty_q;
  end else begin : g_std
    logic [DATA_WIDTH-1:0] dout_q;
    logic                  dout_valid_q;

    always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else if (CLR) begin
        dout_q       <= '0;
        dout_valid_q <= 1'b0;
      end else begin
        dout_valid_q <= rd_acc;
        if (rd_acc) dout_q <= mem[rd_ptr_q];
      end
    end

    assign bus.Dout       = dout_q;
    assign bus.Dout_valid = dout_valid_q;
  end

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.Empty        = empty_q;
  assign bus.almost_full  = af_q;
  assign bus.almost_empty = ae_q;
  assign bus.overflow     = ovf_q;
  assign bus.underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Self-checking bench for fifo_sync_param: queue model plus output scoreboard on two
// standard-mode instances (depth 8 and depth 6) and directed checks on an FWFT instance.
module tb_fifo_sync_param;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic clr_a = 1'b0;
  logic clr_b = 1'b0;
  logic clr_c = 1'b0;

  always #5 CLK = ~CLK;

  fifo_sync_param_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) a_if ();
  fifo_sync_param_if #(.DATA_WIDTH(10), .ADDR_WIDTH(3)) b_if ();
  fifo_sync_param_if #(.DATA_WIDTH(10), .ADDR_WIDTH(2)) c_if ();

  fifo_sync_param #(
    .DATA_WIDTH(10), .DEPTH(8), .ADDR_WIDTH(3), .AF_LEVEL(6), .AE_LEVEL(2), .FWFT(0)
  ) u_a (.CLK(CLK), .RST(RST), .CLR(clr_a), .bus(a_if));

  fifo_sync_param #(
    .DATA_WIDTH(10), .DEPTH(6), .ADDR_WIDTH(3), .AF_LEVEL(5), .AE_LEVEL(1), .FWFT(0)
  ) u_b (.CLK(CLK), .RST(RST), .CLR(clr_b), .bus(b_if));

  fifo_sync_param #(
    .DATA_WIDTH(10), .DEPTH(4), .ADDR_WIDTH(2), .AF_LEVEL(3), .AE_LEVEL(1), .FWFT(1)
  ) u_c (.CLK(CLK), .RST(RST), .CLR(clr_c), .bus(c_if));

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  int          m_cnt [2];
  bit          m_ovf [2];
  bit          m_unf [2];
  logic [9:0]  m_dout[2];
  logic [9:0]  mq_a[$];
  logic [9:0]  mq_b[$];
  logic [9:0]  sb[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // One clock of stimulus on instance w (0 = depth 8, 1 = depth 6), then compare to the model.
  task automatic step(input int w, input bit wr, input bit rd, input bit clr,
                      input logic [9:0] din);
    int         depth, af_lvl, ae_lvl;
    bit         ra, wa;
    logic [9:0] g_dout;
    logic [3:0] g_cnt;
    logic       g_dv, g_full, g_empty, g_af, g_ae, g_ovf, g_unf;
    string      p;
    depth  = (w == 0) ? 8 : 6;
    af_lvl = (w == 0) ? 6 : 5;
    ae_lvl = (w == 0) ? 2 : 1;
    p      = (w == 0) ? "a_" : "b_";
    ra = rd && !clr && (m_cnt[w] != 0);
    wa = wr && !clr && ((m_cnt[w] != depth) || ra);
    if (w == 0) begin
      a_if.Din = din; a_if.WR_EN = wr; a_if.RD_EN = rd; clr_a = clr;
    end else begin
      b_if.Din = din; b_if.WR_EN = wr; b_if.RD_EN = rd; clr_b = clr;
    end
    @(posedge CLK);
    if (clr) begin
      if (w == 0) mq_a.delete(); else mq_b.delete();
      m_cnt[w] = 0; m_ovf[w] = 1'b0; m_unf[w] = 1'b0; m_dout[w] = '0;
    end else begin
      if (wr && !wa) m_ovf[w] = 1'b1;
      if (rd && !ra) m_unf[w] = 1'b1;
      if (ra) begin
        if (w == 0) sb.push_back(mq_a.pop_front());
        else        sb.push_back(mq_b.pop_front());
      end
      if (wa) begin
        if (w == 0) mq_a.push_back(din); else mq_b.push_back(din);
      end
      if (wa && !ra) m_cnt[w]++;
      else if (ra && !wa) m_cnt[w]--;
    end
    #1;
    if (w == 0) begin
      g_dout = a_if.Dout; g_dv = a_if.Dout_valid; g_cnt = a_if.count; g_full = a_if.full;
      g_empty = a_if.Empty; g_af = a_if.almost_full; g_ae = a_if.almost_empty;
      g_ovf = a_if.overflow; g_unf = a_if.underflow;
      a_if.WR_EN = 1'b0; a_if.RD_EN = 1'b0; a_if.Din = '0; clr_a = 1'b0;
    end else begin
      g_dout = b_if.Dout; g_dv = b_if.Dout_valid; g_cnt = b_if.count; g_full = b_if.full;
      g_empty = b_if.Empty; g_af = b_if.almost_full; g_ae = b_if.almost_empty;
      g_ovf = b_if.overflow; g_unf = b_if.underflow;
      b_if.WR_EN = 1'b0; b_if.RD_EN = 1'b0; b_if.Din = '0; clr_b = 1'b0;
    end
    if (g_dv && sb.size() != 0) m_dout[w] = sb.pop_front();
    check_eq({p, "count"},        g_cnt,   m_cnt[w]);
    check_eq({p, "dout_valid"},   g_dv,    ra);
    check_eq({p, "dout"},         g_dout,  m_dout[w]);
    check_eq({p, "full"},         g_full,  m_cnt[w] == depth);
    check_eq({p, "empty"},        g_empty, m_cnt[w] == 0);
    check_eq({p, "almost_full"},  g_af,    m_cnt[w] >= af_lvl);
    check_eq({p, "almost_empty"}, g_ae,    m_cnt[w] <= ae_lvl);
    check_eq({p, "overflow"},     g_ovf,   m_ovf[w]);
    check_eq({p, "underflow"},    g_unf,   m_unf[w]);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0; m_ovf[i] = 1'b0; m_unf[i] = 1'b0; m_dout[i] = '0;
    end
    a_if.Din = '0; a_if.WR_EN = 1'b0; a_if.RD_EN = 1'b0;
    b_if.Din = '0; b_if.WR_EN = 1'b0; b_if.RD_EN = 1'b0;
    c_if.Din = '0; c_if.WR_EN = 1'b0; c_if.RD_EN = 1'b0;

    #1 RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    check_eq("rst_a_empty",        a_if.Empty,        1);
    check_eq("rst_a_almost_empty", a_if.almost_empty, 1);
    check_eq("rst_a_count",        a_if.count,        0);
    check_eq("rst_a_full",         a_if.full,         0);
    check_eq("rst_c_dout_valid",   c_if.Dout_valid,   0);
    @(negedge CLK);
    RST = 1'b1;
    @(posedge CLK);
    #1;

    // Fill, overflow, drain, underflow.
    for (int i = 1; i <= 8; i++) step(0, 1'b1, 1'b0, 1'b0, 10'(i));
    step(0, 1'b1, 1'b0, 1'b0, 10'h009);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, 1'b0, '0);
    step(0, 1'b0, 1'b1, 1'b0, '0);

    // Simultaneous write and read on a full FIFO, then on an empty one.
    step(0, 1'b0, 1'b0, 1'b1, '0);
    for (int i = 1; i <= 8; i++) step(0, 1'b1, 1'b0, 1'b0, 10'h010 + 10'(i));
    step(0, 1'b1, 1'b1, 1'b0, 10'h3FF);
    for (int i = 0; i < 8; i++) step(0, 1'b0, 1'b1, 1'b0, '0);
    step(0, 1'b1, 1'b1, 1'b0, 10'h0AB);

    // CLR with a concurrent write at count 5 and underflow still set.
    for (int i = 0; i < 4; i++) step(0, 1'b1, 1'b0, 1'b0, 10'h0C0 + 10'(i));
    step(0, 1'b1, 1'b0, 1'b1, 10'h0EE);
    step(0, 1'b0, 1'b0, 1'b0, '0);

    // Non-power-of-two depth: interleaved traffic across several pointer wraps.
    for (int i = 0; i < 4; i++) step(1, 1'b1, 1'b0, 1'b0, 10'h100 + 10'(i));
    for (int i = 0; i < 30; i++) step(1, (i % 4) != 3, (i % 3) != 0, 1'b0, 10'h140 + 10'(i));
    for (int i = 0; i < 7; i++) step(1, 1'b0, 1'b1, 1'b0, '0);

    // FWFT: word is visible after its write edge, popping exposes the next one.
    c_if.Din = 10'h055; c_if.WR_EN = 1'b1;
    @(posedge CLK); #1;
    c_if.WR_EN = 1'b0;
    check_eq("c_dout_first",  c_if.Dout,       10'h055);
    check_eq("c_valid_first", c_if.Dout_valid, 1);
    @(posedge CLK); #1;
    check_eq("c_dout_hold",   c_if.Dout,       10'h055);
    c_if.RD_EN = 1'b1;
    @(posedge CLK); #1;
    c_if.RD_EN = 1'b0;
    check_eq("c_empty_pop",   c_if.Empty,      1);
    check_eq("c_valid_pop",   c_if.Dout_valid, 0);
    c_if.Din = 10'h0AA; c_if.WR_EN = 1'b1;
    @(posedge CLK); #1;
    c_if.Din = 10'h0BB;
    @(posedge CLK); #1;
    c_if.WR_EN = 1'b0;
    check_eq("c_dout_aa",     c_if.Dout,       10'h0AA);
    check_eq("c_count_2",     c_if.count,      2);
    c_if.RD_EN = 1'b1;
    @(posedge CLK); #1;
    c_if.RD_EN = 1'b0;
    check_eq("c_dout_bb",     c_if.Dout,       10'h0BB);
    check_eq("c_valid_bb",    c_if.Dout_valid, 1);

    // Asynchronous reset between clock edges in the middle of a burst.
    for (int i = 0; i < 7; i++) step(0, 1'b1, 1'b0, 1'b0, 10'h021 + 10'(i));
    step(0, 1'b0, 1'b1, 1'b0, '0);
    a_if.Din = 10'h1AA; a_if.WR_EN = 1'b1; a_if.RD_EN = 1'b1;
    @(posedge CLK);
    #3 RST = 1'b0;
    #1;
    check_eq("arst_a_count",       a_if.count,        0);
    check_eq("arst_a_empty",       a_if.Empty,        1);
    check_eq("arst_a_almost_empty", a_if.almost_empty, 1);
    check_eq("arst_a_almost_full", a_if.almost_full,  0);
    check_eq("arst_a_dout",        a_if.Dout,         0);
    check_eq("arst_a_dout_valid",  a_if.Dout_valid,   0);
    check_eq("arst_c_empty",       c_if.Empty,        1);
    a_if.WR_EN = 1'b0; a_if.RD_EN = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
